// File: rtl/stopwatch_counter.sv
// Prescaled MM:SS BCD stopwatch (00:00..59:59) with synchronous clear and a
// lap function that freezes the display while the time keeps running.
module stopwatch_counter #(
    parameter int DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_en,
    input  logic        clr,
    input  logic        lap,
    output logic        sec_tick,
    output logic        wrap,
    output logic        lap_frozen,
    output logic [15:0] disp
);

    localparam int            PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    typedef enum logic {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } lap_state_t;

    lap_state_t    state_q;
    lap_state_t    state_d;
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_d;
    logic [3:0]    m_tens, m_ones, s_tens, s_ones;
    logic [3:0]    m_tens_d, m_ones_d, s_tens_d, s_ones_d;
    logic [15:0]   hold;
    logic [15:0]   live;
    logic          tick;
    logic          wrap_d;
    logic          capture;

    assign live = {m_tens, m_ones, s_tens, s_ones};
    // count_en is sampled on the terminal edge itself, so a pause landing there
    // suppresses the advance.
    assign tick = count_en && (pre == PRE_MAX);

    always_comb begin
        pre_d = pre;
        if (count_en) begin
            pre_d = (pre == PRE_MAX) ? '0 : pre + PW'(1);
        end
    end

    // BCD ripple; the >= compares keep digits legal even from a corrupt value.
    always_comb begin
        s_ones_d = s_ones;
        s_tens_d = s_tens;
        m_ones_d = m_ones;
        m_tens_d = m_tens;
        wrap_d   = 1'b0;
        if (tick) begin
            if (s_ones < 4'd9) begin
                s_ones_d = s_ones + 4'd1;
            end else begin
                s_ones_d = 4'd0;
                if (s_tens < 4'd5) begin
                    s_tens_d = s_tens + 4'd1;
                end else begin
                    s_tens_d = 4'd0;
                    if (m_ones < 4'd9) begin
                        m_ones_d = m_ones + 4'd1;
                    end else begin
                        m_ones_d = 4'd0;
                        if (m_tens < 4'd5) begin
                            m_tens_d = m_tens + 4'd1;
                        end else begin
                            m_tens_d = 4'd0;
                            wrap_d   = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Lap FSM: clr forces LIVE, otherwise each lap pulse toggles.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        if (clr) begin
            state_d = LIVE;
        end else if (lap) begin
            if (state_q == LIVE) begin
                state_d = FROZEN;
                capture = 1'b1;
            end else begin
                state_d = LIVE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LIVE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre      <= '0;
            m_tens   <= 4'd0;
            m_ones   <= 4'd0;
            s_tens   <= 4'd0;
            s_ones   <= 4'd0;
            hold     <= 16'h0000;
            sec_tick <= 1'b0;
            wrap     <= 1'b0;
        end else if (clr) begin
            pre      <= '0;
            m_tens   <= 4'd0;
            m_ones   <= 4'd0;
            s_tens   <= 4'd0;
            s_ones   <= 4'd0;
            hold     <= 16'h0000;
            sec_tick <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            pre      <= pre_d;
            m_tens   <= m_tens_d;
            m_ones   <= m_ones_d;
            s_tens   <= s_tens_d;
            s_ones   <= s_ones_d;
            // Hold takes the pre-advance time when lap and tick share an edge.
            if (capture) begin
                hold <= live;
            end
            sec_tick <= tick;
            wrap     <= wrap_d;
        end
    end

    assign lap_frozen = (state_q == FROZEN);
    assign disp       = lap_frozen ? hold : live;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter at DIV=4: expected tick events are
// queued by the stimulus and consumed by a monitor on every sec_tick pulse.
module tb_stopwatch_counter;

    localparam int DIV = 4;
    localparam int W   = 49;  // {cycle[31:0], wrap, disp[15:0]}

    logic        clk;
    logic        rst;
    logic        count_en;
    logic        clr;
    logic        lap;
    logic        sec_tick;
    logic        wrap;
    logic        lap_frozen;
    logic [15:0] disp;

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;
    int           base;

    stopwatch_counter #(.DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_en   (count_en),
        .clr        (clr),
        .lap        (lap),
        .sec_tick   (sec_tick),
        .wrap       (wrap),
        .lap_frozen (lap_frozen),
        .disp       (disp)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Seconds count to MM:SS BCD by plain arithmetic.
    function automatic logic [15:0] to_bcd(input int n);
        int m;
        int s;
        m = (n % 3600) / 60;
        s = n % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic push(input int at_cyc, input logic w, input logic [15:0] d);
        exp_q.push_back({32'(at_cyc), w, d});
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst      = 1'b0;
        count_en = 1'b0;
        clr      = 1'b0;
        lap      = 1'b0;
        cycles(2);
        check("rst_disp", 32'(disp), 32'h0000);
        check("rst_lap_frozen", 32'(lap_frozen), 0);
        check("rst_sec_tick", 32'(sec_tick), 0);
        check("rst_wrap", 32'(wrap), 0);
        rst  = 1'b1;
        base = cyc;
    endtask

    task automatic pulse_lap;
        lap = 1'b1;
        cycles(1);
        lap = 1'b0;
    endtask

    task automatic drain(input string name);
        count_en = 1'b0;
        cycles(2);
        check(name, 32'(exp_q.size()), 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("wrap_without_tick", 32'(wrap & ~sec_tick), 0);
            if (sec_tick) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tick", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check("tick_cycle", 32'(cyc), e[48:17]);
                    check("tick_wrap", 32'(wrap), 32'(e[16]));
                    check("tick_disp", 32'(disp), 32'(e[15:0]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b0;
        count_en = 1'b0;
        clr      = 1'b0;
        lap      = 1'b0;

        // 1: async reset while running at 00:07 with the display frozen.
        // Lap lands on the 7th tick edge, so the hold captures 00:06.
        do_reset();
        count_en = 1'b1;
        for (int n = 1; n <= 6; n++) push(base + 4 * n, 1'b0, to_bcd(n));
        push(base + 28, 1'b0, 16'h0006);
        cycles(27);
        pulse_lap();
        cycles(1);
        check("t1_frozen_before_rst", 32'(lap_frozen), 1);
        check("t1_pending", 32'(exp_q.size()), 0);
        #2;
        rst = 1'b0;
        #1;
        check("t1_async_disp", 32'(disp), 32'h0000);
        check("t1_async_lap_frozen", 32'(lap_frozen), 0);
        check("t1_async_sec_tick", 32'(sec_tick), 0);
        check("t1_async_wrap", 32'(wrap), 0);
        cycles(6);
        check("t1_held_sec_tick", 32'(sec_tick), 0);
        check("t1_held_disp", 32'(disp), 32'h0000);

        // 2: 40 counting cycles -> ten ticks 4 cycles apart, 00:10.
        do_reset();
        count_en = 1'b1;
        for (int n = 1; n <= 10; n++) push(base + 4 * n, 1'b0, to_bcd(n));
        cycles(40);
        check("t2_disp", 32'(disp), 32'h0010);
        drain("t2_pending");

        // 3: pause keeps the partial second; pause on the terminal edge.
        do_reset();
        push(base + 4, 1'b0, 16'h0001);
        push(base + 28, 1'b0, 16'h0002);
        push(base + 36, 1'b0, 16'h0003);
        count_en = 1'b1;
        cycles(6);
        count_en = 1'b0;
        cycles(20);
        count_en = 1'b1;
        cycles(2);
        check("t3_disp_two_ticks", 32'(disp), 32'h0002);
        cycles(3);
        count_en = 1'b0;
        cycles(4);
        check("t3_no_advance_paused", 32'(disp), 32'h0002);
        count_en = 1'b1;
        cycles(1);
        check("t3_resume_disp", 32'(disp), 32'h0003);
        drain("t3_pending");

        // 4: full hour, 59:59 -> 00:00 with wrap on the 3600th tick.
        do_reset();
        for (int n = 1; n <= 3600; n++) push(base + 4 * n, n == 3600, to_bcd(n));
        count_en = 1'b1;
        cycles(4 * 3599);
        check("t4_disp_5959", 32'(disp), 32'h5959);
        cycles(4);
        check("t4_disp_0000", 32'(disp), 32'h0000);
        drain("t4_pending");

        // 5: lap at 00:03 freezes the display while time runs to 00:05.
        do_reset();
        for (int n = 1; n <= 3; n++) push(base + 4 * n, 1'b0, to_bcd(n));
        push(base + 16, 1'b0, 16'h0003);
        push(base + 20, 1'b0, 16'h0003);
        count_en = 1'b1;
        cycles(12);
        pulse_lap();
        cycles(8);
        check("t5_frozen_disp", 32'(disp), 32'h0003);
        check("t5_frozen_flag", 32'(lap_frozen), 1);
        pulse_lap();
        check("t5_live_disp", 32'(disp), 32'h0005);
        check("t5_live_flag", 32'(lap_frozen), 0);
        drain("t5_pending");

        // 6: clr + lap on the tick edge at 00:09; count restarts from pre=0.
        do_reset();
        for (int n = 1; n <= 9; n++) push(base + 4 * n, 1'b0, to_bcd(n));
        push(base + 44, 1'b0, 16'h0001);
        count_en = 1'b1;
        cycles(39);
        clr = 1'b1;
        lap = 1'b1;
        cycles(1);
        clr = 1'b0;
        lap = 1'b0;
        check("t6_clr_disp", 32'(disp), 32'h0000);
        check("t6_clr_lap_frozen", 32'(lap_frozen), 0);
        check("t6_clr_sec_tick", 32'(sec_tick), 0);
        check("t6_clr_wrap", 32'(wrap), 0);
        cycles(4);
        check("t6_resume_disp", 32'(disp), 32'h0001);
        drain("t6_pending");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
